// File: rtl/button_gesture_decoder.sv
// Groups debounced short-press pulses into single/double/triple clicks and
// recognises long presses and click-then-hold. Decoded events are queued in a
// small FIFO and handed out over a valid/ready interface.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no click group open; waiting for a short or long press
// COLLECT | click group open; counting clicks, timer measures the gap
module button_gesture_decoder #(
  parameter int unsigned WINDOW_CYCLES = 25000000,
  parameter int unsigned MAX_CLICKS    = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       short_i,
  input  logic       long_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [2:0] evt_code_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [2:0]    MAX_CODE   = 3'(MAX_CLICKS);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  localparam logic [2:0] CODE_SINGLE     = 3'd1;
  localparam logic [2:0] CODE_LONG       = 3'd4;
  localparam logic [2:0] CODE_CLICK_LONG = 3'd5;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      clicks_q, clicks_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push_req;
  logic [2:0]      push_code;
  logic [2:0]      clicks_inc;

  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            fifo_empty, fifo_full;
  logic            do_push, do_pop, do_drop;

  assign clicks_inc = {1'b0, clicks_q} + 3'd1;

  // Gesture FSM state, click count and gap timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      clicks_q <= 2'd0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state and event decision; a long press always wins over a short one.
  always_comb begin
    state_d   = state_q;
    clicks_d  = clicks_q;
    timer_d   = timer_q;
    push_req  = 1'b0;
    push_code = 3'd0;
    case (state_q)
      IDLE: begin
        if (long_i) begin
          push_req  = 1'b1;
          push_code = CODE_LONG;
        end else if (short_i) begin
          if (MAX_CLICKS == 1) begin
            push_req  = 1'b1;
            push_code = CODE_SINGLE;
          end else begin
            state_d  = COLLECT;
            clicks_d = 2'd1;
            timer_d  = '0;
          end
        end
      end
      COLLECT: begin
        if (long_i) begin
          push_req  = 1'b1;
          push_code = CODE_CLICK_LONG;
          state_d   = IDLE;
          clicks_d  = 2'd0;
          timer_d   = '0;
        end else if (short_i && (clicks_inc == MAX_CODE)) begin
          push_req  = 1'b1;
          push_code = MAX_CODE;
          state_d   = IDLE;
          clicks_d  = 2'd0;
          timer_d   = '0;
        end else if (short_i) begin
          // A click in the final timer cycle still counts as in-window.
          clicks_d = clicks_q + 2'd1;
          timer_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          push_req  = 1'b1;
          push_code = {1'b0, clicks_q};
          state_d   = IDLE;
          clicks_d  = 2'd0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        clicks_d = 2'd0;
        timer_d  = '0;
      end
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign do_pop     = ~fifo_empty & evt_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push    = push_req & (~fifo_full | do_pop);
  assign do_drop    = push_req & fifo_full & ~do_pop;

  // Event storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
      if (do_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign evt_valid_o = ~fifo_empty;
  assign evt_code_o  = fifo_empty ? 3'd0 : mem_q[rd_ptr_q];
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q == COLLECT);

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: directed gesture scenarios with literal
// expectations, then randomized presses/backpressure/resets, all compared
// every cycle against a queue-based behavioural model.
module tb_button_gesture_decoder;

  localparam int W     = 16;
  localparam int MAXC  = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       short_i = 1'b0;
  logic       long_i = 1'b0;
  logic       evt_ready_i = 1'b1;
  logic       evt_valid_o;
  logic [2:0] evt_code_o;
  logic       overflow_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  int     mq[$];
  bit     m_ovf = 1'b0;
  bit     m_open = 1'b0;
  int     m_n = 0;
  longint cyc = 0;
  longint last_click = 0;

  button_gesture_decoder #(
    .WINDOW_CYCLES(W),
    .MAX_CLICKS(MAXC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .short_i(short_i),
    .long_i(long_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_code_o(evt_code_o),
    .overflow_o(overflow_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: gaps measured as absolute cycle distances, FIFO as a queue.
  initial begin
    forever begin
      int  ev;
      bit  pop;
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_open = 1'b0;
        m_n    = 0;
      end else begin
        ev  = 0;
        pop = (mq.size() > 0) && evt_ready_i;
        if (!m_open) begin
          if (long_i) ev = 4;
          else if (short_i) begin
            if (MAXC == 1) ev = 1;
            else begin
              m_open = 1'b1;
              m_n = 1;
              last_click = cyc;
            end
          end
        end else begin
          if (long_i) begin
            ev = 5;
            m_open = 1'b0;
          end else if (short_i && (m_n + 1 == MAXC)) begin
            ev = MAXC;
            m_open = 1'b0;
          end else if (short_i) begin
            m_n++;
            last_click = cyc;
          end else if (cyc - last_click == W) begin
            ev = m_n;
            m_open = 1'b0;
          end
        end
        if (pop) void'(mq.pop_front());
        if (ev != 0) begin
          if (mq.size() < DEPTH) mq.push_back(ev);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_valid", int'(evt_valid_o), int'(mq.size() > 0));
        chk("model_code", int'(evt_code_o), (mq.size() > 0) ? mq[0] : 0);
        chk("model_overflow", int'(overflow_o), int'(m_ovf));
        chk("model_busy", int'(busy_o), int'(m_open));
      end
    end
  end

  task automatic step(input bit s, input bit l);
    short_i = s;
    long_i  = l;
    @(negedge clk);
    short_i = 1'b0;
    long_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", int'(evt_valid_o), 0);
    chk("rst_code", int'(evt_code_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst = 1'b0;
    idle(2);

    // single click with timeout
    step(1'b1, 1'b0);
    chk("single_busy_rise", int'(busy_o), 1);
    idle(15);
    chk("single_before_timeout", int'(evt_valid_o), 0);
    chk("single_busy_hold", int'(busy_o), 1);
    idle(1);
    chk("single_valid", int'(evt_valid_o), 1);
    chk("single_code", int'(evt_code_o), 1);
    chk("single_busy_fall", int'(busy_o), 0);
    idle(2);

    // double click, second click at timer = 14
    step(1'b1, 1'b0);
    idle(14);
    step(1'b1, 1'b0);
    idle(15);
    chk("double14_early", int'(evt_valid_o), 0);
    idle(1);
    chk("double14_code", int'(evt_code_o), 2);
    idle(2);

    // double click, second click exactly at timer = 15
    step(1'b1, 1'b0);
    idle(15);
    step(1'b1, 1'b0);
    chk("double15_no_single", int'(evt_valid_o), 0);
    chk("double15_busy", int'(busy_o), 1);
    idle(15);
    chk("double15_early", int'(evt_valid_o), 0);
    idle(1);
    chk("double15_code", int'(evt_code_o), 2);
    idle(2);

    // triple closes immediately
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0);
    chk("triple_code", int'(evt_code_o), 3);
    chk("triple_busy", int'(busy_o), 0);
    idle(2);

    // third press coincides with long
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(1); step(1'b1, 1'b1);
    chk("triple_long_code", int'(evt_code_o), 5);
    idle(2);

    // click then hold
    step(1'b1, 1'b0); idle(4); step(1'b0, 1'b1);
    chk("click_long_code", int'(evt_code_o), 5);
    chk("click_long_busy", int'(busy_o), 0);
    idle(2);

    // long in idle, then coincident short+long in idle
    step(1'b0, 1'b1);
    chk("long_code", int'(evt_code_o), 4);
    idle(1);
    chk("long_drained", int'(evt_valid_o), 0);
    step(1'b1, 1'b1);
    chk("coincident_code", int'(evt_code_o), 4);
    chk("coincident_busy", int'(busy_o), 0);
    idle(1);
    chk("coincident_one_event", int'(evt_valid_o), 0);

    // backpressure, full push+pop, overflow, drain
    evt_ready_i = 1'b0;
    repeat (4) step(1'b0, 1'b1);
    chk("full_valid", int'(evt_valid_o), 1);
    chk("full_no_ovf", int'(overflow_o), 0);
    evt_ready_i = 1'b1;
    step(1'b0, 1'b1);
    chk("full_pushpop_no_ovf", int'(overflow_o), 0);
    evt_ready_i = 1'b0;
    step(1'b0, 1'b1);
    chk("overflow_set", int'(overflow_o), 1);
    evt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", int'(evt_valid_o), 1);
      chk("drain_code", int'(evt_code_o), 4);
      idle(1);
    end
    chk("drain_empty", int'(evt_valid_o), 0);
    chk("overflow_sticky", int'(overflow_o), 1);

    // reset mid-operation
    evt_ready_i = 1'b0;
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0);
    chk("pre_rst_busy", int'(busy_o), 1);
    chk("pre_rst_valid", int'(evt_valid_o), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("post_rst_valid", int'(evt_valid_o), 0);
    chk("post_rst_code", int'(evt_code_o), 0);
    chk("post_rst_overflow", int'(overflow_o), 0);
    chk("post_rst_busy", int'(busy_o), 0);
    idle(20);
    chk("post_rst_no_event", int'(evt_valid_o), 0);
    chk("post_rst_idle", int'(busy_o), 0);
    evt_ready_i = 1'b1;

    // randomized traffic with occasional stalls and resets
    for (int i = 0; i < 6000; i++) begin
      bit slow;
      slow = ((i / 300) % 3) == 1;
      evt_ready_i = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) == 0);
      step($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_gesture_decoder.md
# button_gesture_decoder

Downstream consumer of the push-button debouncer's single-cycle `short_tact` / `long_tact` pulses. It groups short presses arriving within a configurable time window into single, double and triple clicks. It also recognises long presses and click-then-hold sequences. Decoded events are queued in a small FIFO and handed to the game/control logic over a valid/ready interface, so a slow consumer never loses a gesture while the queue has room.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 25000000: inter-click window in clk cycles (250 ms at 100 MHz); must be ≥ 2.
- `MAX_CLICKS`, default 3: click count that closes a group immediately; legal range 1..3.
- `FIFO_DEPTH`, default 4: event queue depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `short_i`  in  1  one-cycle pulse: short press completed (from debouncer `short_tact`).
- `long_i`  in  1  one-cycle pulse: long press detected (from debouncer `long_tact`).
- `evt_valid_o`  out  1  FIFO non-empty; `evt_code_o` is valid.
- `evt_ready_i`  in  1  consumer accepts the head event when high together with `evt_valid_o`.
- `evt_code_o`  out  3  head event code: 1 = SINGLE, 2 = DOUBLE, 3 = TRIPLE, 4 = LONG, 5 = CLICK_LONG. Value 0 is never queued.
- `overflow_o`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `busy_o`  out  1  high while a click group is open (FSM not in IDLE).

## Operation
- FSM states: IDLE, COLLECT.
- Registers:
  - `clicks`: 2 bits.
  - `timer`: $clog2(WINDOW_CYCLES) bits, unsigned, never wraps.
  - FIFO: `FIFO_DEPTH` entries × 3 bits, with read/write pointers and a count that is one bit wider than the pointers.
- IDLE:
  - `long_i`: push LONG (4); stay in IDLE.
  - `short_i` alone, with `MAX_CLICKS` = 1: push SINGLE; stay in IDLE.
  - `short_i` alone, otherwise: `clicks` ← 1, `timer` ← 0, go to COLLECT.
- COLLECT, priority order:
  1. `long_i`: push CLICK_LONG (5) whatever the click count; go to IDLE.
  2. `short_i`, and `clicks+1` == `MAX_CLICKS`: push code `MAX_CLICKS`; go to IDLE.
  3. `short_i` otherwise: `clicks` ← `clicks+1`, `timer` ← 0.
  4. `timer` == `WINDOW_CYCLES-1`: push code = `clicks`; go to IDLE.
  5. Otherwise: `timer` ← `timer+1`.
- Simultaneous `short_i` and `long_i`: `long_i` wins and `short_i` is ignored, in both states.
- FIFO:
  - Push occurs when the FSM decides an event.
  - Pop occurs when `evt_valid_o & evt_ready_i`.
  - Push and pop in the same cycle are both performed and the count is unchanged. This applies when full: a push coincident with a pop is accepted, not dropped.
  - Push while full with no pop: the event is discarded and `overflow_o` ← 1.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `evt_code_o` = head entry when non-empty, 0 when empty.
- `overflow_o` is cleared only by `rst`.
- `rst` in any state: FSM → IDLE, `clicks`/`timer` = 0, FIFO emptied. The open group and all queued events are discarded; no event is emitted for them.

## Timing
- Reset values: `evt_valid_o` = 0, `evt_code_o` = 0, `overflow_o` = 0, `busy_o` = 0.
- Event latency: a push decided in cycle N raises `evt_valid_o` in cycle N+1 if the FIFO was empty. The path is fully registered; there is no combinational path from `short_i` or `long_i` to any output.
- Timeout: the last `short_i` in cycle N gives `timer` = 0 in N+1. The timeout decision is in cycle N+`WINDOW_CYCLES`, and the event is visible in N+`WINDOW_CYCLES`+1.
- A `short_i` in the exact timeout cycle (`timer` == `WINDOW_CYCLES-1`) counts as in-window; rule 3 beats rule 4.
- `busy_o`: rises the cycle after the opening `short_i`; falls the cycle after the closing decision.
- A pop in cycle N removes the head; the next entry (or 0 / not-valid) appears in N+1.
- Throughput: one push and one pop per cycle maximum.

## Test plan
- Single click, `WINDOW_CYCLES` = 16: `short_i` at cycle 10 → `busy_o` = 1 at cycle 11; `evt_valid_o` = 1 with `evt_code_o` = 1 at cycle 27; `busy_o` = 0 at cycle 27.
- Double click and window edge: `short_i` at 10 and at 25 (timer = 14) → one DOUBLE (2) at cycle 42. Also `short_i` at 10 and at 26 (timer = 15, boundary) → DOUBLE, not two SINGLEs.
- Triple click closes early, `MAX_CLICKS` = 3: `short_i` at 10, 12, 14 → TRIPLE (3) valid at cycle 15, no timeout wait. Repeat with `short_i` and `long_i` asserted together at 14 → CLICK_LONG (5) at 15.
- Long and click-long: `long_i` in IDLE → code 4 next cycle. `short_i` then `long_i` 5 cycles later → code 5, `busy_o` falls. A coincident `short_i` and `long_i` in IDLE → code 4 only.
- Backpressure and overflow, `FIFO_DEPTH` = 4: hold `evt_ready_i` = 0 and generate 5 LONG events → 4 queued, `overflow_o` = 1. Release `evt_ready_i` → codes 4,4,4,4 drain one per cycle, then `evt_valid_o` = 0 and `overflow_o` stays 1. With the FIFO full, push and pop in the same cycle → count stays 4 and no new overflow.
- Reset mid-operation: two clicks open and 2 events queued; assert `rst` for 1 cycle → all outputs at reset values next cycle, and no event appears after `WINDOW_CYCLES`.
